// File: rtl/port_txq_pkg.sv
// Shared types and constants for the per-port transmit queue.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package port_txq_pkg;

  // Write-side frame assembly states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_DROP   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Descriptor layout: length occupies [LEN_MSB:0], upper bits are zero.
  localparam int LEN_MSB = 10;
  localparam int LEN_W   = LEN_MSB + 1;
  localparam int DESC_W  = 16;

  // Default frame size limits in bytes, FCS excluded.
  localparam int DEF_MAX_LEN = 1514;
  localparam int DEF_MIN_LEN = 14;

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Latency: o_dout valid the cycle after an accepted pop; o_empty falls the cycle after a push.
// Backpressure: pop on empty is ignored; push on full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_dout;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // When full, the slot being popped this cycle is read before it is overwritten.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_dout;

  // Storage write; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr[AW-1:0]] <= i_din;
    end
  end

  // Pointer advance and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_dout <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_dout <= r_mem[r_rd[AW-1:0]];
        r_rd   <= r_rd + 1'b1;
      end
    end
  end

endmodule

// File: rtl/port_txq.sv
// Per-port transmit queue: buffers fabric frames, commits clean ones as length descriptors.
// Latency: descriptor visible 2 cycles after the eof beat; popped byte/descriptor valid 1 cycle after rd.
// Backpressure: in_ready low at frame start unless a max-size frame and a descriptor slot fit; low in FINISH.
module port_txq
  import port_txq_pkg::*;
#(
  parameter int DATA_AW = 12,
  parameter int PTR_AW  = 5,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int MIN_LEN = DEF_MIN_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_err,
  input  logic        data_fifo_rd,
  output logic [7:0]  data_fifo_dout,
  input  logic        ptr_fifo_rd,
  output logic [15:0] ptr_fifo_dout,
  output logic        ptr_fifo_empty,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int                DEPTH     = 2**DATA_AW;
  localparam logic [DATA_AW:0]  C_DEPTH   = (DATA_AW+1)'(DEPTH);
  localparam logic [DATA_AW:0]  C_MAX_PTR = (DATA_AW+1)'(MAX_LEN);
  localparam logic [LEN_MSB:0]  C_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [LEN_MSB:0]  C_MIN_LEN = LEN_W'(MIN_LEN);

  // Byte buffer and its three pointers (one extra MSB for wrap detection).
  logic [7:0]       r_mem [DEPTH];
  logic [DATA_AW:0] r_wr_tent;
  logic [DATA_AW:0] r_wr_cmt;
  logic [DATA_AW:0] r_rd;
  logic [7:0]       r_dout;

  // Frame assembly state.
  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_MSB:0] r_len;
  logic             r_err;
  logic             r_ovs;
  logic             r_init;
  logic [15:0]      r_frame_cnt;
  logic [15:0]      r_drop_cnt;

  // Admission and control strobes.
  logic [DATA_AW:0] w_used;
  logic [DATA_AW:0] w_free;
  logic             w_space_ok;
  logic             w_desc_full;
  logic             w_ready;
  logic             w_start;
  logic             w_wr_en;
  logic             w_len_inc;
  logic             w_abort;
  logic             w_commit;
  logic             w_reject;
  logic             w_data_pop;
  logic [DESC_W-1:0] w_desc_din;

  // Free space is judged against tentative writes so an in-flight frame is accounted for.
  assign w_used     = r_wr_tent - r_rd;
  assign w_free     = C_DEPTH - w_used;
  assign w_space_ok = (w_free >= C_MAX_PTR) & ~w_desc_full;
  // Reads never run past the committed pointer, so uncommitted bytes stay invisible.
  assign w_data_pop = data_fifo_rd & (r_rd != r_wr_cmt);
  assign w_desc_din = {{(DESC_W-LEN_W){1'b0}}, r_len};

  assign in_ready       = w_ready;
  assign data_fifo_dout = r_dout;
  assign frame_cnt      = r_frame_cnt;
  assign drop_cnt       = r_drop_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-beat control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_start     = 1'b0;
    w_wr_en     = 1'b0;
    w_len_inc   = 1'b0;
    w_abort     = 1'b0;
    w_commit    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Stray non-sof beats are swallowed here without counting as drops.
        w_ready = r_init & w_space_ok;
        if (in_valid && w_ready && in_sof) begin
          w_start     = 1'b1;
          w_wr_en     = 1'b1;
          w_state_nxt = in_eof ? ST_FINISH : ST_RECV;
        end
      end
      ST_RECV: begin
        w_ready = 1'b1;
        if (in_valid) begin
          if (in_sof) begin
            // A new sof inside a frame means the current one is broken.
            w_abort     = 1'b1;
            w_state_nxt = in_eof ? ST_IDLE : ST_DROP;
          end else begin
            w_len_inc = 1'b1;
            // Stop storing past the max size so the admitted space is never exceeded.
            w_wr_en   = (r_len < C_MAX_LEN);
            if (in_eof) begin
              w_state_nxt = ST_FINISH;
            end
          end
        end
      end
      ST_DROP: begin
        w_ready = 1'b1;
        if (in_valid && in_eof) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FINISH: begin
        if (r_err || r_ovs || (r_len < C_MIN_LEN)) begin
          w_reject = 1'b1;
        end else begin
          w_commit = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame length, error/oversize flags, write pointers and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init      <= 1'b0;
      r_len       <= '0;
      r_err       <= 1'b0;
      r_ovs       <= 1'b0;
      r_wr_tent   <= '0;
      r_wr_cmt    <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_init <= 1'b1;
      if (w_start) begin
        r_len <= LEN_W'(1);
        r_ovs <= 1'b0;
        r_err <= in_eof & in_err;
      end else if (w_len_inc) begin
        if (r_len != '1) begin
          r_len <= r_len + LEN_W'(1);
        end
        if (!w_wr_en) begin
          r_ovs <= 1'b1;
        end
        if (in_eof) begin
          r_err <= in_err;
        end
      end
      if (w_abort || w_reject) begin
        r_wr_tent <= r_wr_cmt;
      end else if (w_wr_en) begin
        r_wr_tent <= r_wr_tent + 1'b1;
      end
      if (w_commit) begin
        r_wr_cmt    <= r_wr_tent;
        r_frame_cnt <= sat_inc16(r_frame_cnt);
      end
      if (w_abort || w_reject) begin
        r_drop_cnt <= sat_inc16(r_drop_cnt);
      end
    end
  end

  // Byte buffer write port; unreset storage.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_tent[DATA_AW-1:0]] <= in_data;
    end
  end

  // Byte read port: registered data, holds when the pop is refused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd   <= '0;
      r_dout <= '0;
    end else if (w_data_pop) begin
      r_dout <= r_mem[r_rd[DATA_AW-1:0]];
      r_rd   <= r_rd + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DESC_W),
    .AW    (PTR_AW)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_commit),
    .i_din   (w_desc_din),
    .i_pop   (ptr_fifo_rd),
    .o_dout  (ptr_fifo_dout),
    .o_full  (w_desc_full),
    .o_empty (ptr_fifo_empty)
  );

endmodule

// File: tb/tb_port_txq.sv
// Directed bench for port_txq with a queue-level reference model and literal pins.
// Latency: checks descriptors/counters 2 cycles after eof, popped bytes 1 cycle after rd.
// Backpressure: every wait on in_ready is bounded; an expired bound counts as a failure.
module tb_port_txq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sof;
  logic        in_eof;
  logic        in_err;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout;
  logic        ptr_fifo_rd;
  logic [15:0] ptr_fifo_dout;
  logic        ptr_fifo_empty;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  port_txq dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_sof         (in_sof),
    .in_eof         (in_eof),
    .in_err         (in_err),
    .data_fifo_rd   (data_fifo_rd),
    .data_fifo_dout (data_fifo_dout),
    .ptr_fifo_rd    (ptr_fifo_rd),
    .ptr_fifo_dout  (ptr_fifo_dout),
    .ptr_fifo_empty (ptr_fifo_empty),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: committed bytes and descriptors in order, plus counters.
  logic [7:0]  exp_data[$];
  logic [15:0] exp_desc[$];
  int          exp_frames = 0;
  int          exp_drops  = 0;

  logic        dchk = 1'b0;
  logic [7:0]  dexp = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Popped-byte comparison, active on every cycle following a data pop.
  always @(negedge clk) begin
    if (dchk) check("data_dout", {24'h0, data_fifo_dout}, {24'h0, dexp});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_ready();
    return ((4096 - exp_data.size()) >= 1514) && (exp_desc.size() < 32);
  endfunction

  task automatic beat(input logic [7:0] d, input logic s, input logic e, input logic er);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    in_eof   = e;
    in_err   = er;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", {31'h0, in_ready}, 32'h1);
    tick();
  endtask

  task automatic send_frame(input int n, input bit er, input int seed, input int abort_at);
    for (int i = 0; i < n; i++) begin
      beat(8'(seed + i), (i == 0) || (i == abort_at), i == n - 1, er && (i == n - 1));
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    in_err   = 1'b0;
    if (abort_at > 0 || er || n < 14 || n > 1514) begin
      exp_drops++;
    end else begin
      for (int i = 0; i < n; i++) exp_data.push_back(8'(seed + i));
      exp_desc.push_back(16'(n));
      exp_frames++;
    end
    tick();
    tick();
    check("frame_cnt", {16'h0, frame_cnt}, 32'(exp_frames));
    check("drop_cnt", {16'h0, drop_cnt}, 32'(exp_drops));
    check("desc_empty", {31'h0, ptr_fifo_empty}, {31'h0, exp_desc.size() == 0});
    check("in_ready_idle", {31'h0, in_ready}, {31'h0, model_ready()});
  endtask

  task automatic pop_desc(output logic [15:0] got);
    logic [15:0] e;
    e = exp_desc.pop_front();
    ptr_fifo_rd = 1'b1;
    tick();
    ptr_fifo_rd = 1'b0;
    @(negedge clk);
    got = ptr_fifo_dout;
    check("desc_dout", {16'h0, ptr_fifo_dout}, {16'h0, e});
  endtask

  task automatic pop_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      data_fifo_rd = 1'b1;
      tick();
      dexp = exp_data.pop_front();
      dchk = 1'b1;
    end
    data_fifo_rd = 1'b0;
    @(negedge clk);
    #1;
    dchk = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    in_sof       = 1'b0;
    in_eof       = 1'b0;
    in_err       = 1'b0;
    data_fifo_rd = 1'b0;
    ptr_fifo_rd  = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_dout", {24'h0, data_fifo_dout}, 32'h0);
    check("rst_desc_dout", {16'h0, ptr_fifo_dout}, 32'h0);
    check("rst_empty", {31'h0, ptr_fifo_empty}, 32'h1);
    check("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    check("rst_drop_cnt", {16'h0, drop_cnt}, 32'h0);
    rst = 1'b0;
    tick();
    tick();

    // Pop with nothing committed is ignored.
    data_fifo_rd = 1'b1;
    tick();
    data_fifo_rd = 1'b0;
    @(negedge clk);
    check("empty_pop_hold", {24'h0, data_fifo_dout}, 32'h0);
    check("empty_pop_flag", {31'h0, ptr_fifo_empty}, 32'h1);
    tick();

    // 60-byte clean frame 00..3B.
    send_frame(60, 1'b0, 0, -1);
    check("t1_frame_cnt", {16'h0, frame_cnt}, 32'h1);
    pop_desc(d);
    check("t1_desc", {16'h0, d}, 32'h003C);
    pop_bytes(60);
    check("t1_last_byte", {24'h0, data_fifo_dout}, 32'h3B);
    data_fifo_rd = 1'b1;
    tick();
    data_fifo_rd = 1'b0;
    @(negedge clk);
    check("t1_overpop_hold", {24'h0, data_fifo_dout}, 32'h3B);
    tick();

    // 100-byte errored frame.
    send_frame(100, 1'b1, 8'h20, -1);
    check("t2_drop_cnt", {16'h0, drop_cnt}, 32'h1);
    check("t2_empty", {31'h0, ptr_fifo_empty}, 32'h1);

    // Oversize frame, then a clean 64-byte frame.
    send_frame(1600, 1'b0, 0, -1);
    check("t3_drop_cnt", {16'h0, drop_cnt}, 32'h2);
    send_frame(64, 1'b0, 8'h55, -1);
    pop_desc(d);
    check("t3_desc", {16'h0, d}, 32'h0040);
    pop_bytes(64);

    // Runt and single sof+eof beat.
    send_frame(10, 1'b0, 8'h10, -1);
    send_frame(1, 1'b0, 8'h90, -1);
    check("t4_drop_cnt", {16'h0, drop_cnt}, 32'h4);

    // Size boundaries and mid-frame sof abort.
    send_frame(14, 1'b0, 8'h03, -1);
    send_frame(13, 1'b0, 8'h30, -1);
    send_frame(1515, 1'b0, 8'h07, -1);
    send_frame(40, 1'b0, 8'hA0, 10);
    check("t5_drop_cnt", {16'h0, drop_cnt}, 32'h7);
    check("t5_frame_cnt", {16'h0, frame_cnt}, 32'h3);
    pop_desc(d);
    check("t5_desc_min", {16'h0, d}, 32'h000E);
    pop_bytes(14);

    // Fill with max-size frames until admission closes, then drain one.
    send_frame(1514, 1'b0, 8'h05, -1);
    check("t6_ready_one", {31'h0, in_ready}, 32'h1);
    send_frame(1514, 1'b0, 8'hC1, -1);
    check("t6_ready_full", {31'h0, in_ready}, 32'h0);
    pop_desc(d);
    check("t6_desc_max", {16'h0, d}, 32'h05EA);
    pop_bytes(1514);
    tick();
    check("t6_ready_reopen", {31'h0, in_ready}, 32'h1);
    check("t6_ready_model", {31'h0, in_ready}, {31'h0, model_ready()});
    pop_desc(d);
    pop_bytes(1514);

    // Reset mid-frame with a committed frame still queued.
    send_frame(20, 1'b0, 8'h40, -1);
    for (int i = 0; i < 30; i++) beat(8'(8'h60 + i), i == 0, 1'b0, 1'b0);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst      = 1'b1;
    #2;
    check("t7_rst_ready", {31'h0, in_ready}, 32'h0);
    check("t7_rst_empty", {31'h0, ptr_fifo_empty}, 32'h1);
    check("t7_rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    check("t7_rst_drop_cnt", {16'h0, drop_cnt}, 32'h0);
    check("t7_rst_dout", {24'h0, data_fifo_dout}, 32'h0);
    tick();
    rst = 1'b0;
    exp_data.delete();
    exp_desc.delete();
    exp_frames = 0;
    exp_drops  = 0;
    tick();
    send_frame(16, 1'b0, 8'h80, -1);
    pop_desc(d);
    check("t7_desc", {16'h0, d}, 32'h0010);
    pop_bytes(16);
    check("t7_last_byte", {24'h0, data_fifo_dout}, 32'h8F);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
